// File: rtl/set_mode_ctrl.sv
// Button conditioning and setting-mode sequencer in front of the alarm/time-setting block.
// Four raw buttons are synchronised and debounced into press pulses that drive the field-select FSM.
module set_mode_ctrl #(
    parameter int DEB_CYCLES     = 20,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button1,
    input  logic       button2,
    input  logic       button3,
    input  logic       button4,
    output logic       setting_toggle,
    output logic [1:0] tap_out,
    output logic       inc_pulse,
    output logic       alm_set_pulse,
    output logic [3:0] btn_level
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SET_SEC  = 2'd1,
        SET_MIN  = 2'd2,
        SET_HOUR = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [3:0]       raw;
    logic [3:0]       raw_s1;
    logic [3:0]       raw_s2;
    logic [3:0]       level;
    logic [3:0]       level_q;
    logic [3:0]       press;
    logic [CNT_W-1:0] deb_cnt [4];
    logic [CNT_W-1:0] to_cnt;
    state_t           state;
    state_t           state_nxt;
    logic             in_set;
    logic             any_press;
    logic             expire;

    assign raw       = {button4, button3, button2, button1};
    assign btn_level = level;

    function automatic logic [1:0] tap_of(input state_t s);
        case (s)
            SET_MIN:  tap_of = 2'd1;
            SET_HOUR: tap_of = 2'd2;
            default:  tap_of = 2'd0;
        endcase
    endfunction

    function automatic state_t advance(input state_t s);
        case (s)
            IDLE:     advance = SET_SEC;
            SET_SEC:  advance = SET_MIN;
            SET_MIN:  advance = SET_HOUR;
            default:  advance = IDLE;
        endcase
    endfunction

    // Stage 1: synchronise, debounce, and turn rising debounced levels into one-cycle presses
    always_ff @(posedge clk) begin
        if (rst) begin
            raw_s1  <= '0;
            raw_s2  <= '0;
            level   <= '0;
            level_q <= '0;
            press   <= '0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            raw_s1  <= raw;
            raw_s2  <= raw_s1;
            level_q <= level;
            press   <= level & ~level_q;
            for (int i = 0; i < 4; i++) begin
                if (raw_s2[i] == level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    level[i]   <= raw_s2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Stage 2: next-state decode; exit beats advance, and any press in the expiry cycle cancels the timeout
    always_comb begin
        in_set    = (state != IDLE);
        any_press = |press;
        expire    = in_set && !any_press && (to_cnt == TO_LAST);
        state_nxt = state;
        if (in_set) begin
            if (press[3] || expire) begin
                state_nxt = IDLE;
            end else if (press[1]) begin
                state_nxt = advance(state);
            end
        end else if (press[1]) begin
            state_nxt = SET_SEC;
        end
    end

    // Stage 3: registered state, decoded outputs and inactivity counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            setting_toggle <= 1'b0;
            tap_out        <= 2'd0;
            inc_pulse      <= 1'b0;
            alm_set_pulse  <= 1'b0;
            to_cnt         <= '0;
        end else begin
            state          <= state_nxt;
            setting_toggle <= (state_nxt != IDLE);
            tap_out        <= tap_of(state_nxt);
            inc_pulse      <= press[2] && in_set;
            alm_set_pulse  <= press[0];
            if (!in_set || any_press || expire) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + CNT_W'(1);
            end
        end
    end

endmodule
